// File: rtl/ti_simon_pkg.sv
// Shared constants and FSM state type for the threshold Simon mask driver.
package ti_simon_pkg;

    localparam int unsigned SHARE_W = 256;
    localparam int unsigned DIN_W   = 3 * SHARE_W;

    // Share slice offsets inside the core's Din bus: {share_a, share_b, share_c}
    localparam int unsigned A_LSB = 2 * SHARE_W;
    localparam int unsigned B_LSB = SHARE_W;
    localparam int unsigned C_LSB = 0;

    typedef enum logic [2:0] {
        StIdle,
        StGather,
        StLoad,
        StWait,
        StCapture,
        StOutput
    } state_e;

endpackage

// File: rtl/ti_simon_share_split.sv
// Three-way Boolean masking of the secret: two random shares plus the
// secret XORed with both. Kept separate so the masking equation can be reviewed alone.
module ti_simon_share_split
    import ti_simon_pkg::*;
(
    input  logic [SHARE_W-1:0]   secret,
    input  logic [2*SHARE_W-1:0] rnd,
    output logic [DIN_W-1:0]     din
);

    logic [SHARE_W-1:0] mask_a;
    logic [SHARE_W-1:0] mask_b;

    assign mask_a = rnd[SHARE_W-1:0];
    assign mask_b = rnd[2*SHARE_W-1:SHARE_W];

    assign din[A_LSB +: SHARE_W] = mask_a;
    assign din[B_LSB +: SHARE_W] = mask_b;
    assign din[C_LSB +: SHARE_W] = secret ^ mask_a ^ mask_b;

endmodule

// File: rtl/ti_simon_mask_driver.sv
// Host-side initiator for the three-share bit-serial threshold Simon core:
// accepts a secret, gathers fresh randomness, loads masked shares, waits for the
// result under a watchdog and hands it back on a valid/ready port.
module ti_simon_mask_driver
    import ti_simon_pkg::*;
#(
    parameter int unsigned RND_W       = 64,
    parameter int unsigned TIMEOUT_CYC = 8191,
    parameter int unsigned SECRET_W    = 256
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                EN,
    input  logic [SECRET_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RND_W-1:0]    rnd,
    input  logic                rnd_valid,
    output logic                rnd_ready,
    output logic [DIN_W-1:0]    Din,
    output logic                Drdy,
    input  logic                Dvld,
    input  logic                BSY,
    input  logic [127:0]        Dout,
    output logic [127:0]        out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                err_timeout
);

    localparam int unsigned RndBits = 2 * SECRET_W;
    localparam int unsigned Beats   = RndBits / RND_W;
    localparam int unsigned BeatW   = (Beats > 1) ? $clog2(Beats) : 1;
    localparam int unsigned WdogW   = $clog2(TIMEOUT_CYC + 1);

    state_e              state_q, state_d;
    logic [SECRET_W-1:0] secret_q, secret_d;
    logic [RndBits-1:0]  r_q, r_d, r_merge;
    logic [BeatW-1:0]    beat_q, beat_d;
    logic [WdogW-1:0]    wdog_q, wdog_d;
    logic [DIN_W-1:0]    din_q, din_d, din_split;
    logic [127:0]        out_q, out_d;
    logic                dvld_q;
    logic                dvld_rise;
    logic                unused_bsy;

    // BSY is status only; sequencing relies on the Dvld edge.
    assign unused_bsy = BSY;
    assign dvld_rise  = Dvld & ~dvld_q;

    // Shares are computed from the buffer including the beat arriving this cycle,
    // so Din is ready in the very cycle the FSM sits in LOAD.
    ti_simon_share_split u_split (
        .secret (secret_q),
        .rnd    (r_merge),
        .din    (din_split)
    );

    assign Din       = din_q;
    assign out_data  = out_q;
    assign out_valid = (state_q == StOutput);

    // Next-state, datapath updates and gated handshake/strobe outputs.
    always_comb begin
        state_d     = state_q;
        secret_d    = secret_q;
        r_d         = r_q;
        beat_d      = beat_q;
        wdog_d      = wdog_q;
        din_d       = din_q;
        out_d       = out_q;
        in_ready    = 1'b0;
        rnd_ready   = 1'b0;
        Drdy        = 1'b0;
        err_timeout = 1'b0;

        r_merge = r_q;
        for (int i = 0; i < int'(Beats); i++) begin
            if (beat_q == BeatW'(i)) begin
                r_merge[i*RND_W +: RND_W] = rnd;
            end
        end

        unique case (state_q)
            StIdle: begin
                // rst also gates in_ready so every output reads 0 while reset is held
                in_ready = EN & ~rst;
                if (in_valid) begin
                    secret_d = in_data;
                    r_d      = '0;
                    beat_d   = '0;
                    state_d  = StGather;
                end
            end
            StGather: begin
                rnd_ready = EN;
                if (rnd_valid) begin
                    r_d    = r_merge;
                    beat_d = beat_q + BeatW'(1);
                    if (beat_q == BeatW'(Beats - 1)) begin
                        din_d   = din_split;
                        beat_d  = '0;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                Drdy = EN;
                // Scrub the unmasked secret, the used mask and the shares.
                secret_d = '0;
                r_d      = '0;
                din_d    = '0;
                wdog_d   = '0;
                state_d  = StWait;
            end
            StWait: begin
                if (dvld_rise) begin
                    state_d = StCapture;
                end else if (wdog_q == WdogW'(TIMEOUT_CYC)) begin
                    err_timeout = EN;
                    state_d     = StIdle;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            StCapture: begin
                out_d   = Dout;
                state_d = StOutput;
            end
            StOutput: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; EN low freezes everything including the Dvld edge detector.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            secret_q <= '0;
            r_q      <= '0;
            beat_q   <= '0;
            wdog_q   <= '0;
            din_q    <= '0;
            out_q    <= '0;
            dvld_q   <= 1'b0;
        end else if (EN) begin
            state_q  <= state_d;
            secret_q <= secret_d;
            r_q      <= r_d;
            beat_q   <= beat_d;
            wdog_q   <= wdog_d;
            din_q    <= din_d;
            out_q    <= out_d;
            dvld_q   <= Dvld;
        end
    end

endmodule

// File: tb/tb_ti_simon_mask_driver.sv
// Self-checking bench for ti_simon_mask_driver: directed operations with a
// cycle-scheduled expectation model checked every cycle on the falling edge.
module tb_ti_simon_mask_driver;

    localparam int unsigned TO = 100;

    localparam logic [255:0] SEC_A = {4{64'h0123_4567_89AB_CDEF}};
    localparam logic [255:0] PIN_A = 256'hA5A5_0000_0000_0003_A5A5_0000_0000_0002_A5A5_0000_0000_0001_A5A5_0000_0000_0000;
    localparam logic [255:0] PIN_B = 256'hA5A5_0000_0000_0007_A5A5_0000_0000_0006_A5A5_0000_0000_0005_A5A5_0000_0000_0004;
    localparam logic [255:0] PIN_C = 256'h0123_4567_89AB_CDEB_0123_4567_89AB_CDEB_0123_4567_89AB_CDEB_0123_4567_89AB_CDEB;
    localparam logic [127:0] DV_A  = 128'h3B72_6574_7475_432D_6C6F_6F62_6570_6F72;

    logic         CLK = 1'b0;
    logic         rst;
    logic         EN;
    logic [255:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  rnd;
    logic         rnd_valid;
    logic         rnd_ready;
    logic [767:0] Din;
    logic         Drdy;
    logic         Dvld;
    logic         BSY;
    logic [127:0] Dout;
    logic [127:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         err_timeout;

    // Expected outputs for the current cycle
    logic         e_in_ready, e_rnd_ready, e_drdy, e_out_valid, e_err;
    logic [767:0] e_din;
    logic [127:0] e_out_data;
    logic [255:0] cur_sec;
    logic         pin;
    logic         chk_on;
    logic [63:0]  beat_v [8];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    ti_simon_mask_driver #(
        .RND_W       (64),
        .TIMEOUT_CYC (TO),
        .SECRET_W    (256)
    ) dut (
        .CLK         (CLK),
        .rst         (rst),
        .EN          (EN),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rnd         (rnd),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rnd_ready),
        .Din         (Din),
        .Drdy        (Drdy),
        .Dvld        (Dvld),
        .BSY         (BSY),
        .Dout        (Dout),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs against the expectation model every cycle.
    always @(negedge CLK) begin
        if (chk_on) begin
            chk("in_ready",    768'(in_ready),    768'(e_in_ready));
            chk("rnd_ready",   768'(rnd_ready),   768'(e_rnd_ready));
            chk("Drdy",        768'(Drdy),        768'(e_drdy));
            chk("Din",         Din,               e_din);
            chk("out_valid",   768'(out_valid),   768'(e_out_valid));
            chk("out_data",    768'(out_data),    768'(e_out_data));
            chk("err_timeout", 768'(err_timeout), 768'(e_err));
            if (e_drdy) begin
                chk("recombine", 768'(Din[767:512] ^ Din[511:256] ^ Din[255:0]), 768'(cur_sec));
            end
            if (pin) begin
                chk("pin_share_a", 768'(Din[767:512]), 768'(PIN_A));
                chk("pin_share_b", 768'(Din[511:256]), 768'(PIN_B));
                chk("pin_share_c", 768'(Din[255:0]),   768'(PIN_C));
            end
        end
    end

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    task automatic cyc_end();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_exp();
        e_in_ready  = 1'b0;
        e_rnd_ready = 1'b0;
        e_drdy      = 1'b0;
        e_din       = '0;
        e_out_valid = 1'b0;
        e_err       = 1'b0;
        pin         = 1'b0;
    endtask

    // Ten cycles with EN low and junk offered on rnd; nothing may move.
    task automatic en_gap();
        EN = 1'b0;
        repeat (10) begin
            clr_exp();
            rnd_valid = 1'b1;
            rnd       = r64();
            cyc_end();
        end
        rnd_valid = 1'b0;
        EN        = 1'b1;
    endtask

    // One operation. dvld_at: enabled WAIT cycle in which Dvld rises (<0: never).
    // rst_at: enabled WAIT cycle in which reset is asserted (<0: never).
    task automatic op(input logic [255:0] sec, input bit stall, input bit gap_g, input bit gap_w,
                      input int dvld_at, input logic [127:0] dv, input int hold, input int rst_at,
                      input bit pin_it);
        logic [511:0] r;
        r       = '0;
        cur_sec = sec;
        // accept
        clr_exp();
        in_data    = sec;
        in_valid   = 1'b1;
        e_in_ready = 1'b1;
        cyc_end();
        in_valid = 1'b0;
        in_data  = ~sec;
        // gather
        for (int k = 0; k < 8; k++) begin
            if (stall && k > 0) begin
                repeat (2) begin
                    clr_exp();
                    e_rnd_ready = 1'b1;
                    rnd_valid   = 1'b0;
                    rnd         = r64();
                    cyc_end();
                end
            end
            if (gap_g && k == 4) en_gap();
            clr_exp();
            e_rnd_ready = 1'b1;
            rnd_valid   = 1'b1;
            rnd         = beat_v[k];
            r[k*64 +: 64] = beat_v[k];
            cyc_end();
        end
        rnd_valid = 1'b0;
        // load
        clr_exp();
        e_drdy = 1'b1;
        e_din  = {r[255:0], r[511:256], sec ^ r[255:0] ^ r[511:256]};
        pin    = pin_it;
        cyc_end();
        // wait (n counts enabled WAIT cycles only)
        for (int n = 0; n <= int'(TO); n++) begin
            if (gap_w && n == 2) en_gap();
            if (n == rst_at) begin
                rst = 1'b1;
                clr_exp();
                e_out_data = '0;
                cyc_end();
                cyc_end();
                rst = 1'b0;
                clr_exp();
                e_in_ready = 1'b1;
                cyc_end();
                return;
            end
            clr_exp();
            if (n == dvld_at) begin
                Dvld = 1'b1;
                Dout = dv;
                cyc_end();
                break;
            end
            if (dvld_at < 0 && n == int'(TO)) begin
                e_err = 1'b1;
                cyc_end();
                clr_exp();
                e_in_ready = 1'b1;
                cyc_end();
                return;
            end
            cyc_end();
        end
        // capture cycle: Dvld and Dout still held by the core
        clr_exp();
        cyc_end();
        Dvld = 1'b0;
        Dout = {r64(), r64()};
        // output: held until out_ready; a Dvld edge here must be ignored
        for (int h = 0; h <= hold; h++) begin
            clr_exp();
            e_out_valid = 1'b1;
            e_out_data  = dv;
            out_ready   = (h == hold);
            Dvld        = (h == 1);
            cyc_end();
        end
        out_ready = 1'b0;
        Dvld      = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        EN        = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        rnd       = '0;
        rnd_valid = 1'b0;
        Dvld      = 1'b0;
        BSY       = 1'b0;
        Dout      = '0;
        out_ready = 1'b0;
        chk_on    = 1'b0;
        cur_sec   = '0;
        e_out_data = '0;
        clr_exp();
        repeat (2) @(posedge CLK);
        #1;
        chk_on = 1'b1;
        cyc_end();
        rst = 1'b0;
        clr_exp();
        e_in_ready = 1'b1;
        cyc_end();

        // Mask correctness with the pinned beats, full loop with out_ready held off 5 cycles
        for (int k = 0; k < 8; k++) beat_v[k] = 64'hA5A5_0000_0000_0000 | 64'(k);
        op(SEC_A, 1'b0, 1'b0, 1'b0, 5, DV_A, 5, -1, 1'b1);

        // rnd stalls, Dvld rising in the first WAIT cycle, immediate accept
        for (int k = 0; k < 8; k++) beat_v[k] = r64();
        op({r64(), r64(), r64(), r64()}, 1'b1, 1'b0, 1'b0, 0, {r64(), r64()}, 0, -1, 1'b0);

        // Watchdog expiry
        for (int k = 0; k < 8; k++) beat_v[k] = r64();
        op({r64(), r64(), r64(), r64()}, 1'b0, 1'b0, 1'b0, -1, '0, 0, -1, 1'b0);

        // Watchdog expiry with EN low mid-GATHER and mid-WAIT (shifted by 10 each)
        for (int k = 0; k < 8; k++) beat_v[k] = r64();
        op({r64(), r64(), r64(), r64()}, 1'b0, 1'b1, 1'b1, -1, '0, 0, -1, 1'b0);

        // Full loop with both EN gaps
        for (int k = 0; k < 8; k++) beat_v[k] = r64();
        op({r64(), r64(), r64(), r64()}, 1'b0, 1'b1, 1'b1, 20, {r64(), r64()}, 2, -1, 1'b0);

        // Dvld edge in the very cycle the watchdog expires: result wins, no error
        for (int k = 0; k < 8; k++) beat_v[k] = r64();
        op({r64(), r64(), r64(), r64()}, 1'b0, 1'b0, 1'b0, int'(TO), {r64(), r64()}, 1, -1, 1'b0);

        // Reset 3 cycles into WAIT
        for (int k = 0; k < 8; k++) beat_v[k] = r64();
        op({r64(), r64(), r64(), r64()}, 1'b0, 1'b0, 1'b0, -1, '0, 0, 3, 1'b0);

        clr_exp();
        e_in_ready = 1'b1;
        cyc_end();
        chk_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
